alu_decoder: RTL and testbench

- Opcode decoder for the CE1202 ALU.
- Converts a 4-bit ALU opcode into one-hot operation-select strobes that drive the ALU datapath.
- Strobes are registered on `clk`, so the ALU sees glitch-free selects one cycle after the opcode is presented.
- Sits between instruction decode (source of `op`) and the ALU function units.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_decoder.sv | 29 ++
 tb/tb_alu_decoder.sv | 119 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared CE1202 ALU opcode width, opcode values and one-hot decode
package alu_pkg;

    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_INC  = 4'd2,
        OP_DEC  = 4'd3,
        OP_NEG  = 4'd4,
        OP_INV  = 4'd5,
        OP_ANDL = 4'd6,
        OP_ORL  = 4'd7,
        OP_EQU  = 4'd8,
        OP_CMP  = 4'd9,
        OP_MULS = 4'd10
    } alu_op_e;

    // Bit k selects opcode k for k<=10; bit 11 flags the unassigned codes.
    function automatic logic [11:0] decode_op(input logic [ALU_OP_W-1:0] op);
        return (op <= OP_MULS) ? 12'd1 << op : 12'h800;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: registered one-hot operation-select strobes from the ALU opcode
module alu_decoder
    import alu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [ALU_OP_W-1:0] op,
    output logic                add,
    output logic                sub,
    output logic                inc,
    output logic                dec,
    output logic                neg,
    output logic                inv,
    output logic                andl,
    output logic                orl,
    output logic                equ,
    output logic                cmp,
    output logic                muls,
    output logic                illegal
);

    logic [11:0] sel;

    always_ff @(posedge clk)
        sel <= rst ? 12'd0 : decode_op(op);

    assign {illegal, muls, cmp, equ, orl, andl, inv, neg, dec, inc, sub, add} = sel;

endmodule

// File: tb/tb_alu_decoder.sv
// tb_alu_decoder: table-driven and random checks of the registered opcode decoder
module tb_alu_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] op  = 4'd0;
    logic add, sub, inc, dec, neg, inv, andl, orl, equ, cmp, muls, illegal;
    logic [11:0] outs;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        r;
        logic [3:0]  o;
        logic [11:0] e;
    } vec_t;

    vec_t tbl[$];

    alu_decoder dut (
        .clk(clk), .rst(rst), .op(op),
        .add(add), .sub(sub), .inc(inc), .dec(dec), .neg(neg), .inv(inv),
        .andl(andl), .orl(orl), .equ(equ), .cmp(cmp), .muls(muls), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign outs = {illegal, muls, cmp, equ, orl, andl, inv, neg, dec, inc, sub, add};

    // Reference: each strobe asserted only for its own opcode, illegal for 11..15.
    function automatic logic [11:0] model(input logic r, input int o);
        logic [11:0] m;
        m = '0;
        if (!r) begin
            m[0]  = (o == 0);
            m[1]  = (o == 1);
            m[2]  = (o == 2);
            m[3]  = (o == 3);
            m[4]  = (o == 4);
            m[5]  = (o == 5);
            m[6]  = (o == 6);
            m[7]  = (o == 7);
            m[8]  = (o == 8);
            m[9]  = (o == 9);
            m[10] = (o == 10);
            m[11] = (o >= 11);
        end
        return m;
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %03h expected %03h", name, act, exp);
        end
    endtask

    task automatic check_onehot(input string name);
        vectors++;
        if ($countones(outs) != 1) begin
            miscompares++;
            $display("FAIL %s onehot: got %03h expected exactly one bit set", name, outs);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] o);
        rst = r;
        op  = o;
        @(posedge clk);
        #1;
    endtask

    task automatic v(input logic r, input logic [3:0] o, input logic [11:0] e);
        tbl.push_back('{r, o, e});
    endtask

    initial begin
        v(1, 0, 12'h000); v(1, 0, 12'h000); v(0, 0, 12'h001);
        v(0, 0, 12'h001); v(0, 1, 12'h002); v(0, 2, 12'h004); v(0, 3, 12'h008);
        v(0, 4, 12'h010); v(0, 5, 12'h020); v(0, 6, 12'h040); v(0, 7, 12'h080);
        v(0, 8, 12'h100); v(0, 9, 12'h200); v(0, 10, 12'h400); v(0, 11, 12'h800);
        v(0, 12, 12'h800); v(0, 13, 12'h800); v(0, 14, 12'h800); v(0, 15, 12'h800);
        v(0, 10, 12'h400); v(1, 10, 12'h000); v(0, 10, 12'h400);
        v(0, 10, 12'h400); v(0, 11, 12'h800); v(0, 15, 12'h800); v(0, 0, 12'h001);

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].o);
            check($sformatf("vec%0d op=%0d rst=%0b", i, tbl[i].o, tbl[i].r), outs, tbl[i].e);
            if (!tbl[i].r) check_onehot($sformatf("vec%0d", i));
        end

        // Latency: op switches 5->9 between edges; inv must hold until the next edge.
        step(0, 5);
        check("lat inv after edge", outs, 12'h020);
        op = 4'd9;
        #2;
        check("lat inv holds between edges", outs, 12'h020);
        @(posedge clk);
        #1;
        check("lat cmp after next edge", outs, 12'h200);

        // Reset priority mid-stream, then random opcodes against the model.
        step(1, 4'd7);
        check("rst priority", outs, 12'h000);
        for (int i = 0; i < 200; i++) begin
            logic [3:0] o;
            o = 4'($urandom_range(0, 15));
            step(0, o);
            check($sformatf("rand%0d op=%0d", i, o), outs, model(1'b0, int'(o)));
            check_onehot($sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
